// File: rtl/branch_redirect_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_redirect_ctrl_if
//  Purpose  : Bundles the EX-stage resolve inputs, the fetch redirect
//             handshake, the IF/ID flush and squash controls, the predictor
//             update strobe and the statistics outputs of
//             branch_redirect_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
interface branch_redirect_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             ex_valid_i;
  logic             ex_is_cf_i;
  logic [31:0]      ex_pc_i;
  logic             ex_pred_taken_i;
  logic [31:0]      ex_pred_target_i;
  logic             br_taken_i;
  logic [31:0]      br_target_i;
  logic             redirect_valid_o;
  logic [31:0]      redirect_pc_o;
  logic             redirect_ready_i;
  logic             flush_if_o;
  logic             flush_id_o;
  logic             squash_fetch_o;
  logic             bp_upd_valid_o;
  logic [31:0]      bp_upd_pc_o;
  logic             bp_upd_taken_o;
  logic [31:0]      bp_upd_target_o;
  logic [CNT_W-1:0] stat_branches_o;
  logic [CNT_W-1:0] stat_mispredicts_o;

  // Controller side
  modport master (
    input  ex_valid_i, ex_is_cf_i, ex_pc_i, ex_pred_taken_i, ex_pred_target_i,
    input  br_taken_i, br_target_i, redirect_ready_i,
    output redirect_valid_o, redirect_pc_o, flush_if_o, flush_id_o,
    output squash_fetch_o, bp_upd_valid_o, bp_upd_pc_o, bp_upd_taken_o,
    output bp_upd_target_o, stat_branches_o, stat_mispredicts_o
  );

  // Pipeline / fetch side
  modport slave (
    output ex_valid_i, ex_is_cf_i, ex_pc_i, ex_pred_taken_i, ex_pred_target_i,
    output br_taken_i, br_target_i, redirect_ready_i,
    input  redirect_valid_o, redirect_pc_o, flush_if_o, flush_id_o,
    input  squash_fetch_o, bp_upd_valid_o, bp_upd_pc_o, bp_upd_taken_o,
    input  bp_upd_target_o, stat_branches_o, stat_mispredicts_o
  );
endinterface
`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : branch_redirect_ctrl
//  Purpose  : Control-flow recovery around the EX-stage branch unit. Detects
//             mispredicts, issues a PC redirect to fetch with IF/ID flush,
//             squashes DRAIN_CYCLES of wrong-path fetch responses afterwards,
//             and pulses one predictor update per resolved branch/jump.
//  Options  : BF_BRANCH_STATS_EN - when defined, saturating resolve and
//             mispredict counters drive the stat outputs; otherwise they
//             are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_redirect_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  wire                   clk_i,
  input  wire                   rst_i,
  branch_redirect_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_DRAIN    = 2'd2
  } state_t;

  // Drain counter counts down to zero, so it is preloaded with N-1.
  localparam logic [3:0] c_drain_init =
    (DRAIN_CYCLES > 0) ? 4'(DRAIN_CYCLES - 1) : 4'd0;

  state_t      r_state;
  logic [3:0]  r_drain_cnt;
  logic        r_redirect_valid;
  logic [31:0] r_redirect_pc;
  logic        r_flush;
  logic        r_squash;
  logic        r_upd_valid;
  logic [31:0] r_upd_pc;
  logic        r_upd_taken;
  logic [31:0] r_upd_target;

  logic        w_resolve;
  logic        w_mispredict;
  logic [31:0] w_correct_pc;

  // Resolve qualification, mispredict detection and correct next PC
  always_comb begin
    w_resolve    = (r_state == ST_IDLE) && bus.ex_valid_i && bus.ex_is_cf_i;
    w_mispredict = (bus.br_taken_i != bus.ex_pred_taken_i) ||
                   (bus.br_taken_i && bus.ex_pred_taken_i &&
                    (bus.br_target_i != bus.ex_pred_target_i));
    w_correct_pc = bus.br_taken_i ? bus.br_target_i : (bus.ex_pc_i + 32'd4);
  end

  // Recovery FSM with registered redirect/flush/squash and update outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state          <= ST_IDLE;
      r_drain_cnt      <= 4'd0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'd0;
      r_flush          <= 1'b0;
      r_squash         <= 1'b0;
      r_upd_valid      <= 1'b0;
      r_upd_pc         <= 32'd0;
      r_upd_taken      <= 1'b0;
      r_upd_target     <= 32'd0;
    end else begin
      r_upd_valid <= w_resolve;
      if (w_resolve) begin
        r_upd_pc     <= bus.ex_pc_i;
        r_upd_taken  <= bus.br_taken_i;
        r_upd_target <= bus.br_target_i;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_resolve && w_mispredict) begin
            r_state          <= ST_REDIRECT;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= w_correct_pc;
            r_flush          <= 1'b1;
          end
        end
        ST_REDIRECT: begin
          // redirect_pc stays put until fetch takes it
          if (bus.redirect_ready_i) begin
            r_redirect_valid <= 1'b0;
            r_flush          <= 1'b0;
            if (DRAIN_CYCLES == 0) begin
              r_state <= ST_IDLE;
            end else begin
              r_state     <= ST_DRAIN;
              r_squash    <= 1'b1;
              r_drain_cnt <= c_drain_init;
            end
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == 4'd0) begin
            r_state  <= ST_IDLE;
            r_squash <= 1'b0;
          end else begin
            r_drain_cnt <= r_drain_cnt - 4'd1;
          end
        end
        default: begin
          r_state          <= ST_IDLE;
          r_redirect_valid <= 1'b0;
          r_flush          <= 1'b0;
          r_squash         <= 1'b0;
          r_drain_cnt      <= 4'd0;
        end
      endcase
    end
  end

  assign bus.redirect_valid_o = r_redirect_valid;
  assign bus.redirect_pc_o    = r_redirect_pc;
  assign bus.flush_if_o       = r_flush;
  assign bus.flush_id_o       = r_flush;
  assign bus.squash_fetch_o   = r_squash;
  assign bus.bp_upd_valid_o   = r_upd_valid;
  assign bus.bp_upd_pc_o      = r_upd_pc;
  assign bus.bp_upd_taken_o   = r_upd_taken;
  assign bus.bp_upd_target_o  = r_upd_target;

`ifdef BF_BRANCH_STATS_EN
  logic [CNT_W-1:0] r_stat_br;
  logic [CNT_W-1:0] r_stat_mp;

  // Saturating resolve and mispredict counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stat_br <= '0;
      r_stat_mp <= '0;
    end else begin
      if (w_resolve && (r_stat_br != {CNT_W{1'b1}})) begin
        r_stat_br <= r_stat_br + 1'b1;
      end
      if (w_resolve && w_mispredict && (r_stat_mp != {CNT_W{1'b1}})) begin
        r_stat_mp <= r_stat_mp + 1'b1;
      end
    end
  end

  assign bus.stat_branches_o    = r_stat_br;
  assign bus.stat_mispredicts_o = r_stat_mp;
`else
  assign bus.stat_branches_o    = '0;
  assign bus.stat_mispredicts_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_redirect_ctrl
//  Purpose  : Self-checking bench for branch_redirect_ctrl: directed cases
//             followed by random traffic compared against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_redirect_ctrl;

  localparam int DRAIN = 2;
  localparam int CW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  branch_redirect_ctrl_if #(.CNT_W(CW)) bus ();

  branch_redirect_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state: what the outputs must show after the next rising edge
  bit          m_redir;
  logic [31:0] m_pc;
  int          m_drain_left;
  bit          m_upd_v;
  logic [31:0] m_upd_pc;
  bit          m_upd_taken;
  logic [31:0] m_upd_tgt;
  longint      m_br;
  longint      m_mp;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check_val("redirect_valid", 64'(bus.redirect_valid_o), 64'(m_redir));
    if (m_redir) check_val("redirect_pc", 64'(bus.redirect_pc_o), 64'(m_pc));
    check_val("flush_if", 64'(bus.flush_if_o), 64'(m_redir));
    check_val("flush_id", 64'(bus.flush_id_o), 64'(m_redir));
    check_val("squash", 64'(bus.squash_fetch_o), 64'(m_drain_left > 0));
    check_val("upd_valid", 64'(bus.bp_upd_valid_o), 64'(m_upd_v));
    if (m_upd_v) begin
      check_val("upd_pc", 64'(bus.bp_upd_pc_o), 64'(m_upd_pc));
      check_val("upd_taken", 64'(bus.bp_upd_taken_o), 64'(m_upd_taken));
      check_val("upd_target", 64'(bus.bp_upd_target_o), 64'(m_upd_tgt));
    end
`ifdef BF_BRANCH_STATS_EN
    check_val("stat_br", 64'(bus.stat_branches_o), 64'(m_br));
    check_val("stat_mp", 64'(bus.stat_mispredicts_o), 64'(m_mp));
`else
    check_val("stat_br", 64'(bus.stat_branches_o), 64'd0);
    check_val("stat_mp", 64'(bus.stat_mispredicts_o), 64'd0);
`endif
  endtask

  // One clock: apply inputs, advance the model, then check on the falling edge
  task automatic cyc(input bit r, input bit v, input bit cf, input logic [31:0] pc,
                     input bit pt, input logic [31:0] ptg, input bit bt,
                     input logic [31:0] btg, input bit rdy);
    bit idle, resolve, misp;
    rst = r;
    bus.ex_valid_i = v;       bus.ex_is_cf_i = cf;      bus.ex_pc_i = pc;
    bus.ex_pred_taken_i = pt; bus.ex_pred_target_i = ptg;
    bus.br_taken_i = bt;      bus.br_target_i = btg;    bus.redirect_ready_i = rdy;
    if (r) begin
      m_redir = 0; m_pc = 0; m_drain_left = 0; m_upd_v = 0; m_br = 0; m_mp = 0;
    end else begin
      idle    = !m_redir && (m_drain_left == 0);
      resolve = idle && v && cf;
      misp    = (bt != pt) || (bt && pt && (btg != ptg));
      m_upd_v = resolve;
      if (resolve) begin
        m_upd_pc = pc; m_upd_taken = bt; m_upd_tgt = btg;
        m_br++;
        if (misp) m_mp++;
      end
      if (m_redir) begin
        if (rdy) begin
          m_redir      = 0;
          m_drain_left = DRAIN;
        end
      end else if (m_drain_left > 0) begin
        m_drain_left--;
      end else if (resolve && misp) begin
        m_redir = 1;
        m_pc    = bt ? btg : 32'(pc + 32'd4);
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_cyc(input bit rdy);
    cyc(0, 0, 0, 32'd0, 0, 32'd0, 0, 32'd0, rdy);
  endtask

  initial begin
    // Reset
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("rst_redirect_valid", 64'(bus.redirect_valid_o), 64'd0);
    check_val("rst_upd_valid", 64'(bus.bp_upd_valid_o), 64'd0);

    // Correct not-taken at 0x100
    cyc(0, 1, 1, 32'h100, 0, 32'h0, 0, 32'h0, 0);
    check_val("t1_upd_pc", 64'(bus.bp_upd_pc_o), 64'h100);
    check_val("t1_no_redirect", 64'(bus.redirect_valid_o), 64'd0);
    idle_cyc(0);
    check_val("t1_upd_one_cycle", 64'(bus.bp_upd_valid_o), 64'd0);

    // Direction mispredict, ready two cycles late
    cyc(0, 1, 1, 32'h180, 0, 32'h0, 1, 32'h200, 0);
    check_val("t2_redirect_pc", 64'(bus.redirect_pc_o), 64'h200);
    check_val("t2_flush_if", 64'(bus.flush_if_o), 64'd1);
    idle_cyc(0);
    idle_cyc(1);
    check_val("t2_squash", 64'(bus.squash_fetch_o), 64'd1);
    idle_cyc(0);
    idle_cyc(0);
    check_val("t2_squash_done", 64'(bus.squash_fetch_o), 64'd0);

    // Target mispredict; resolve during REDIRECT must be ignored
    cyc(0, 1, 1, 32'h280, 1, 32'h300, 1, 32'h340, 0);
    check_val("t3_redirect_pc", 64'(bus.redirect_pc_o), 64'h340);
    cyc(0, 1, 1, 32'h500, 0, 32'h0, 1, 32'h999, 0);
    check_val("t3_ignored_upd", 64'(bus.bp_upd_valid_o), 64'd0);
    check_val("t3_pc_stable", 64'(bus.redirect_pc_o), 64'h340);
    idle_cyc(1);
    // Resolve on the DRAIN->IDLE cycle is dropped
    idle_cyc(0);
    cyc(0, 1, 1, 32'h600, 0, 32'h0, 1, 32'h700, 0);
    check_val("t3_drain_exit_ignored", 64'(bus.bp_upd_valid_o), 64'd0);

    // Not-taken at the top of the address space wraps to 0
    cyc(0, 1, 1, 32'hFFFF_FFFC, 1, 32'h40, 0, 32'h40, 0);
    check_val("t4_wrap_pc", 64'(bus.redirect_pc_o), 64'h0);
    check_val("t4_valid", 64'(bus.redirect_valid_o), 64'd1);

    // Reset while stuck in REDIRECT
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("t5_valid", 64'(bus.redirect_valid_o), 64'd0);
    check_val("t5_flush", 64'(bus.flush_id_o), 64'd0);
    cyc(0, 1, 1, 32'h800, 0, 32'h0, 0, 32'h0, 0);
    check_val("t5_idle_after_rst", 64'(bus.bp_upd_valid_o), 64'd1);

    // Ten branches, three mispredicts
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 1) begin
        cyc(0, 1, 1, 32'(32'h1000 + i * 4), 0, 32'h0, 1, 32'h2000, 0);
        idle_cyc(1);
        for (int k = 0; k < DRAIN; k++) idle_cyc(0);
      end else begin
        cyc(0, 1, 1, 32'(32'h1000 + i * 4), 1, 32'h3000, 1, 32'h3000, 0);
      end
    end
    idle_cyc(0);
`ifdef BF_BRANCH_STATS_EN
    check_val("t6_branches", 64'(bus.stat_branches_o), 64'd10);
    check_val("t6_mispredicts", 64'(bus.stat_mispredicts_o), 64'd3);
`else
    check_val("t6_branches", 64'(bus.stat_branches_o), 64'd0);
    check_val("t6_mispredicts", 64'(bus.stat_mispredicts_o), 64'd0);
`endif

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc, ptg, btg;
      bit pt, bt;
      pc  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      ptg = 32'h300 + 32'($urandom_range(0, 1) * 32'h40);
      btg = ($urandom_range(0, 3) == 0) ? $urandom() : 32'h300 + 32'($urandom_range(0, 1) * 32'h40);
      pt  = 1'($urandom_range(0, 1));
      bt  = 1'($urandom_range(0, 1));
      cyc(($urandom_range(0, 99) < 2), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
          pc, pt, ptg, bt, btg, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
